// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder: datapath slice width,
// FSM state encodings and nibble counter width.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;
    localparam int CNT_W    = 4;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// 4-bit carry-look-ahead adder used as the per-nibble datapath of the
// serial adder; purely combinational.
module carry_look_ahead_adder_4b (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] sum_o,
    output logic       c_o
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    assign g_s = a_i & b_i;
    assign p_s = a_i ^ b_i;

    assign c_s[0] = c_i;
    assign c_s[1] = g_s[0] | (p_s[0] & c_s[0]);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_s[0]);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & c_s[0]);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_s[0]);

    assign sum_o = p_s ^ c_s[3:0];
    assign c_o   = c_s[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide-operand adder that pushes one nibble per clock through a 4-bit CLA,
// LSB first, with valid/ready handshakes on the operand and result sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*NIBBLES-1:0]  a,
    input  logic [4*NIBBLES-1:0]  b,
    input  logic                  c_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*NIBBLES-1:0]  sum,
    output logic                  c_out,
    output logic                  ovf
);

    localparam int W = NIBBLE_W * NIBBLES;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    logic [1:0]          state_q,  state_d;
    logic [W-1:0]        a_sh_q,   a_sh_d;
    logic [W-1:0]        b_sh_q,   b_sh_d;
    logic [W-1:0]        sum_sh_q, sum_sh_d;
    logic                carry_q,  carry_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                a_msb_q,  a_msb_d;
    logic                b_msb_q,  b_msb_d;
    logic [W-1:0]        sum_q,    sum_d;
    logic                c_out_q,  c_out_d;
    logic                ovf_q,    ovf_d;

    logic [NIBBLE_W-1:0] cla_sum_s;
    logic                cla_c_s;
    logic [W-1:0]        sum_sh_nxt_s;

    carry_look_ahead_adder_4b u_cla (
        .a_i   (a_sh_q[NIBBLE_W-1:0]),
        .b_i   (b_sh_q[NIBBLE_W-1:0]),
        .c_i   (carry_q),
        .sum_o (cla_sum_s),
        .c_o   (cla_c_s)
    );

    // New nibble enters at the top so the LSB nibble ends up at the bottom.
    assign sum_sh_nxt_s = (sum_sh_q >> NIBBLE_W) | (W'(cla_sum_s) << (W - NIBBLE_W));

    // Next-state logic for the sequencer, shift registers and result registers.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = c_in;
                    cnt_d   = {CNT_W{1'b0}};
                    a_msb_d = a[W-1];
                    b_msb_d = b[W-1];
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> NIBBLE_W;
                b_sh_d   = b_sh_q >> NIBBLE_W;
                sum_sh_d = sum_sh_nxt_s;
                carry_d  = cla_c_s;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    sum_d   = sum_sh_nxt_s;
                    c_out_d = cla_c_s;
                    ovf_d   = (a_msb_q == b_msb_q) && (sum_sh_nxt_s[W-1] != a_msb_q);
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= {W{1'b0}};
            b_sh_q   <= {W{1'b0}};
            sum_sh_q <= {W{1'b0}};
            carry_q  <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            sum_q    <= {W{1'b0}};
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            sum_q    <= sum_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: directed scenarios plus random and exhaustive sweeps
// against an arithmetic reference model, on 4-nibble and 1-nibble instances.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv4 = 1'b0, or4 = 1'b0, cin4 = 1'b0;
    logic [15:0] a4 = 16'h0, b4 = 16'h0;
    logic        ir4, ov4, co4, ovf4;
    logic [15:0] sum4;

    logic        iv1 = 1'b0, or1 = 1'b0, cin1 = 1'b0;
    logic [3:0]  a1 = 4'h0, b1 = 4'h0;
    logic        ir1, ov1, co1, ovf1;
    logic [3:0]  sum1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .c_in(cin4), .out_valid(ov4), .out_ready(or4),
        .sum(sum4), .c_out(co4), .ovf(ovf4)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .c_in(cin1), .out_valid(ov1), .out_ready(or1),
        .sum(sum1), .c_out(co1), .ovf(ovf1)
    );

    // Reference: plain unsigned and signed integer arithmetic.
    function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic c);
        int u;
        int s;
        logic v;
        u = int'(a) + int'(b) + int'(c);
        s = int'($signed(a)) + int'($signed(b)) + int'(c);
        v = (s > 32767) || (s < -32768);
        return {v, u[16], u[15:0]};
    endfunction

    function automatic logic [5:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic c);
        int u;
        int s;
        logic v;
        u = int'(a) + int'(b) + int'(c);
        s = int'($signed(a)) + int'($signed(b)) + int'(c);
        v = (s > 7) || (s < -8);
        return {v, u[4], u[3:0]};
    endfunction

    task automatic start_op4(input logic [15:0] a, input logic [15:0] b, input logic c);
        int w = 0;
        while (!ir4 && w < 40) begin
            @(negedge clk);
            w++;
        end
        a4 = a; b4 = b; cin4 = c; iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
    endtask

    task automatic wait_done4(output int lat);
        lat = 0;
        while (!ov4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release4();
        or4 = 1'b1;
        iv4 = 1'b0;
        @(negedge clk);
        or4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({ir4, ov4, sum4, co4, ovf4} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset4: got ir=%b ov=%b sum=%h co=%b ovf=%b, want 1 0 0000 0 0", ir4, ov4, sum4, co4, ovf4);
        end
        n_tests++;
        if ({ir1, ov1, sum1, co1, ovf1} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset1: got ir=%b ov=%b sum=%h co=%b ovf=%b, want 1 0 0 0 0", ir1, ov1, sum1, co1, ovf1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ripple();
        int lat;
        start_op4(16'hFFFF, 16'h0001, 1'b0);
        wait_done4(lat);
        n_tests++;
        if (lat !== 4 || {sum4, co4, ovf4} !== {16'h0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ripple: got lat=%0d sum=%h co=%b ovf=%b, want lat=4 sum=0000 co=1 ovf=0", lat, sum4, co4, ovf4);
        end
        release4();
    endtask

    task automatic test_overflow();
        int lat;
        start_op4(16'h7FFF, 16'h0001, 1'b0);
        wait_done4(lat);
        n_tests++;
        if (lat !== 4 || {sum4, co4, ovf4} !== {16'h8000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL overflow: got lat=%0d sum=%h co=%b ovf=%b, want lat=4 sum=8000 co=0 ovf=1", lat, sum4, co4, ovf4);
        end
        release4();
    endtask

    task automatic test_backpressure();
        int lat;
        start_op4(16'h1234, 16'h4321, 1'b1);
        wait_done4(lat);
        a4 = 16'hFFFF; b4 = 16'hFFFF; cin4 = 1'b1; iv4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if ({ov4, ir4, sum4, co4, ovf4} !== {1'b1, 1'b0, 16'h5556, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL hold[%0d]: got ov=%b ir=%b sum=%h co=%b ovf=%b, want 1 0 5556 0 0", i, ov4, ir4, sum4, co4, ovf4);
            end
            @(negedge clk);
        end
        release4();
        n_tests++;
        if ({ov4, ir4, sum4} !== {1'b0, 1'b1, 16'h5556}) begin
            n_fail++;
            $display("FAIL release: got ov=%b ir=%b sum=%h, want 0 1 5556", ov4, ir4, sum4);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start_op4(16'hABCD, 16'h1111, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ir4, ov4, sum4, co4, ovf4} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort: got ir=%b ov=%b sum=%h co=%b ovf=%b, want 1 0 0000 0 0", ir4, ov4, sum4, co4, ovf4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_op4(16'h0F0F, 16'hF0F0, 1'b1);
        wait_done4(lat);
        n_tests++;
        if (lat !== 4 || {sum4, co4, ovf4} !== {16'h0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL post_abort: got lat=%0d sum=%h co=%b ovf=%b, want lat=4 sum=0000 co=1 ovf=0", lat, sum4, co4, ovf4);
        end
        release4();
    endtask

    task automatic test_exhaustive_n1();
        logic [5:0] exp;
        int lat;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    a1 = 4'(x); b1 = 4'(y); cin1 = 1'(c); iv1 = 1'b1;
                    @(negedge clk);
                    iv1 = 1'b0;
                    lat = 0;
                    while (!ov1 && lat < 10) begin
                        @(negedge clk);
                        lat++;
                    end
                    exp = ref4(4'(x), 4'(y), 1'(c));
                    n_tests++;
                    if (lat !== 1 || {ovf1, co1, sum1} !== exp) begin
                        n_fail++;
                        $display("FAIL n1 %h+%h+%0d: got lat=%0d ovf/co/sum=%b/%b/%h, want lat=1 %b/%b/%h",
                                 x, y, c, lat, ovf1, co1, sum1, exp[5], exp[4], exp[3:0]);
                    end
                    or1 = 1'b1;
                    @(negedge clk);
                    or1 = 1'b0;
                end
            end
        end
    endtask

    task automatic test_random_n4();
        logic [15:0] ra, rb;
        logic        rc;
        logic [17:0] exp;
        int lat;
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            start_op4(ra, rb, rc);
            lat = 0;
            while (!ov4 && lat < 40) begin
                iv4 = 1'($urandom); a4 = 16'($urandom); b4 = 16'($urandom);
                or4 = 1'($urandom);
                @(negedge clk);
                lat++;
            end
            or4 = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                iv4 = 1'($urandom); a4 = 16'($urandom);
                @(negedge clk);
            end
            exp = ref16(ra, rb, rc);
            n_tests++;
            if (lat !== 4 || {ovf4, co4, sum4} !== exp) begin
                n_fail++;
                $display("FAIL rand[%0d] %h+%h+%0d: got lat=%0d ovf/co/sum=%b/%b/%h, want lat=4 %b/%b/%h",
                         k, ra, rb, rc, lat, ovf4, co4, sum4, exp[17], exp[16], exp[15:0]);
            end
            release4();
            n_tests++;
            if ({ov4, sum4} !== {1'b0, exp[15:0]}) begin
                n_fail++;
                $display("FAIL keep[%0d]: got ov=%b sum=%h, want 0 %h", k, ov4, sum4, exp[15:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_exhaustive_n1();
        test_random_n4();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
